// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard logic: forwarding selects, scheduler states, PC index.
// No logic of its own; no latency and no backpressure.
package pipeline_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int unsigned PC_REG = 15;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select, priority EX > MEM > WB; purely combinational.
// A hit on a load in EX is reported as load_hit (stall) instead of an EX forward.
module hazard_fwd_sel
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int PC_REG = pipeline_pkg::PC_REG
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rf_e,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rf_e,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_rf_e,
  output logic [1:0]        fwd,
  output logic              load_hit
);

  logic qual;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // The PC is produced by the fetch path, never by the register-file write ports.
  assign qual    = used && (src != REG_AW'(PC_REG));
  assign ex_hit  = qual && ex_rf_e  && (src == ex_rd);
  assign mem_hit = qual && mem_rf_e && (src == mem_rd);
  assign wb_hit  = qual && wb_rf_e  && (src == wb_rd);

  assign load_hit = ex_hit && ex_load;

  always_comb begin
    fwd = FWD_RF;
    if (ex_hit && !ex_load) fwd = FWD_EX;
    else if (mem_hit)       fwd = FWD_MEM;
    else if (wb_hit)        fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard scheduler: stalls, flushes, freezes and forwarding from a shadow of EX/MEM/WB; outputs combinational.
// Backpressure: mem_ready low on a memory access freezes the whole pipeline until it completes.
module hazard_stall_controller
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16,
  parameter int PC_REG = pipeline_pkg::PC_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_rn_used,
  input  logic              id_rm_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rf_e,
  input  logic              id_load,
  input  logic              id_mem_e,
  input  logic              ex_br_taken,
  input  logic              mem_ready,
  output logic              pc_e,
  output logic              if_id_e,
  output logic              if_id_flush,
  output logic              ctrl_mux_s,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  wait_cnt
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rf_e;
    logic              load;
    logic              mem_e;
  } shadow_t;

  shadow_t ex_q, mem_q, wb_q, id_cap;
  state_t  state_q;

  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       hit_a, hit_b;
  logic       load_use, mem_busy, freeze_c;
  logic       stall_inc, flush_inc, wait_inc;

  hazard_fwd_sel #(.REG_AW(REG_AW), .PC_REG(PC_REG)) u_fwd_rn (
    .src(id_rn), .used(id_rn_used),
    .ex_rd(ex_q.rd), .ex_rf_e(ex_q.rf_e), .ex_load(ex_q.load),
    .mem_rd(mem_q.rd), .mem_rf_e(mem_q.rf_e),
    .wb_rd(wb_q.rd), .wb_rf_e(wb_q.rf_e),
    .fwd(fwd_a_raw), .load_hit(hit_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW), .PC_REG(PC_REG)) u_fwd_rm (
    .src(id_rm), .used(id_rm_used),
    .ex_rd(ex_q.rd), .ex_rf_e(ex_q.rf_e), .ex_load(ex_q.load),
    .mem_rd(mem_q.rd), .mem_rf_e(mem_q.rf_e),
    .wb_rd(wb_q.rd), .wb_rf_e(wb_q.rf_e),
    .fwd(fwd_b_raw), .load_hit(hit_b)
  );

  assign load_use = hit_a || hit_b;
  assign mem_busy = mem_q.mem_e && !mem_ready;
  // The MEM shadow is held during the wait, so mem_busy alone would suffice; the state keeps intent explicit.
  assign freeze_c = mem_busy || ((state_q == MEM_WAIT) && !mem_ready);

  always_comb begin
    pc_e        = 1'b1;
    if_id_e     = 1'b1;
    if_id_flush = 1'b0;
    ctrl_mux_s  = 1'b0;
    pipe_freeze = 1'b0;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;
    if (!reset) begin
      pc_e        = 1'b0;
      if_id_e     = 1'b0;
      if_id_flush = 1'b1;
      ctrl_mux_s  = 1'b1;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end else if (freeze_c) begin
      pc_e        = 1'b0;
      if_id_e     = 1'b0;
      pipe_freeze = 1'b1;
    end else if (ex_br_taken) begin
      if_id_flush = 1'b1;
      ctrl_mux_s  = 1'b1;
    end else if (load_use) begin
      pc_e        = 1'b0;
      if_id_e     = 1'b0;
      ctrl_mux_s  = 1'b1;
    end
  end

  assign wait_inc  = freeze_c;
  assign flush_inc = !freeze_c && ex_br_taken;
  assign stall_inc = !freeze_c && !ex_br_taken && load_use;

  always_comb begin
    id_cap = '0;
    if (id_valid && !ctrl_mux_s) id_cap = '{rd: id_rd, rf_e: id_rf_e, load: id_load, mem_e: id_mem_e};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      state_q   <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state_q <= freeze_c ? MEM_WAIT : RUN;
      if (!freeze_c) begin
        ex_q  <= id_cap;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (wait_inc  && (wait_cnt  != '1)) wait_cnt  <= wait_cnt  + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed vector bench for hazard_stall_controller, plus counter saturation on a narrow-counter instance.
module tb_hazard_stall_controller;

  typedef struct packed {
    logic       v;
    logic [3:0] rn;
    logic [3:0] rm;
    logic       rnu;
    logic       rmu;
    logic [3:0] rd;
    logic       rfe;
    logic       ld;
    logic       me;
  } id_t;

  typedef struct packed {
    logic [4:0]  ctl;  // {pc_e, if_id_e, if_id_flush, ctrl_mux_s, pipe_freeze}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [15:0] wc;
  } exp_t;

  typedef struct {
    logic rst;
    id_t  id;
    logic br;
    logic mrdy;
    exp_t e;
  } vec_t;

  localparam logic [4:0] C_RUN = 5'b11000;
  localparam logic [4:0] C_STL = 5'b00010;
  localparam logic [4:0] C_BR  = 5'b11110;
  localparam logic [4:0] C_FRZ = 5'b00001;
  localparam logic [4:0] C_RST = 5'b00110;

  logic clk = 1'b0;
  logic reset, id_valid, id_rn_used, id_rm_used, id_rf_e, id_load, id_mem_e, ex_br_taken, mem_ready;
  logic [3:0] id_rn, id_rm, id_rd;
  logic pc_e, if_id_e, if_id_flush, ctrl_mux_s, pipe_freeze;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;
  logic s_pc_e, s_if_id_e, s_if_id_flush, s_ctrl_mux_s, s_pipe_freeze;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [3:0] s_stall_cnt, s_flush_cnt, s_wait_cnt;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  hazard_stall_controller dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd(id_rd), .id_rf_e(id_rf_e),
    .id_load(id_load), .id_mem_e(id_mem_e), .ex_br_taken(ex_br_taken), .mem_ready(mem_ready),
    .pc_e(pc_e), .if_id_e(if_id_e), .if_id_flush(if_id_flush), .ctrl_mux_s(ctrl_mux_s),
    .pipe_freeze(pipe_freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  hazard_stall_controller #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd(id_rd), .id_rf_e(id_rf_e),
    .id_load(id_load), .id_mem_e(id_mem_e), .ex_br_taken(ex_br_taken), .mem_ready(mem_ready),
    .pc_e(s_pc_e), .if_id_e(s_if_id_e), .if_id_flush(s_if_id_flush), .ctrl_mux_s(s_ctrl_mux_s),
    .pipe_freeze(s_pipe_freeze), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .wait_cnt(s_wait_cnt)
  );

  function automatic id_t i_gen(logic v, logic [3:0] rn, logic [3:0] rm, logic rnu, logic rmu,
                                logic [3:0] rd, logic rfe, logic ld, logic me);
    id_t r;
    r = '{v: v, rn: rn, rm: rm, rnu: rnu, rmu: rmu, rd: rd, rfe: rfe, ld: ld, me: me};
    return r;
  endfunction

  function automatic id_t i_nop();
    return i_gen(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic id_t i_add(logic [3:0] rd, logic [3:0] rn, logic [3:0] rm);
    return i_gen(1, rn, rm, 1, 1, rd, 1, 0, 0);
  endfunction
  function automatic id_t i_ldr(logic [3:0] rd, logic [3:0] rn);
    return i_gen(1, rn, 0, 1, 0, rd, 1, 1, 1);
  endfunction
  function automatic id_t i_str(logic [3:0] rt, logic [3:0] rn);
    return i_gen(1, rn, rt, 1, 1, 0, 0, 0, 1);
  endfunction

  task automatic add(input logic rst, input id_t id, input logic br, input logic mrdy,
                     input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                     input int sc, input int fc, input int wc);
    vec_t v;
    v.rst = rst; v.id = id; v.br = br; v.mrdy = mrdy;
    v.e = '{ctl: ctl, fa: fa, fb: fb, sc: 16'(sc), fc: 16'(fc), wc: 16'(wc)};
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input id_t id, input logic br, input logic mrdy);
    reset = rst; ex_br_taken = br; mem_ready = mrdy;
    id_valid = id.v; id_rn = id.rn; id_rm = id.rm; id_rn_used = id.rnu; id_rm_used = id.rmu;
    id_rd = id.rd; id_rf_e = id.rfe; id_load = id.ld; id_mem_e = id.me;
  endtask

  task automatic check_vec(input int idx, input exp_t e);
    exp_t got;
    got = '{ctl: {pc_e, if_id_e, if_id_flush, ctrl_mux_s, pipe_freeze},
            fa: fwd_a, fb: fwd_b, sc: stall_cnt, fc: flush_cnt, wc: wait_cnt};
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL vec%0d: got ctl=%b fa=%b fb=%b cnt=%0d/%0d/%0d, want ctl=%b fa=%b fb=%b cnt=%0d/%0d/%0d",
               idx, got.ctl, got.fa, got.fb, got.sc, got.fc, got.wc,
               e.ctl, e.fa, e.fb, e.sc, e.fc, e.wc);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    // reset held low; forwarding chains at distance 1, 2 and 3
    add(0, i_nop(),       0, 1, C_RST, 2'b00, 2'b00, 0, 0, 0);
    add(0, i_nop(),       0, 1, C_RST, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_add(1, 6, 7), 0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_add(2, 1, 3), 0, 1, C_RUN, 2'b01, 2'b00, 0, 0, 0);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_add(1, 6, 7), 0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_add(2, 1, 3), 0, 1, C_RUN, 2'b10, 2'b00, 0, 0, 0);
    add(1, i_add(1, 6, 7), 0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_add(2, 1, 3), 0, 1, C_RUN, 2'b11, 2'b00, 0, 0, 0);
    // priority: EX beats MEM; rn unused suppresses a match
    add(1, i_add(1, 6, 7), 0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_add(1, 6, 7), 0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_add(3, 1, 2), 0, 1, C_RUN, 2'b01, 2'b11, 0, 0, 0);
    add(1, i_gen(1, 1, 1, 0, 1, 0, 0, 0, 0), 0, 1, C_RUN, 2'b00, 2'b10, 0, 0, 0);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    // load-use: one stall, then forward from MEM
    add(1, i_ldr(4, 6),   0, 1, C_RUN, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_add(5, 4, 4), 0, 1, C_STL, 2'b00, 2'b00, 0, 0, 0);
    add(1, i_add(5, 4, 4), 0, 1, C_RUN, 2'b10, 2'b10, 1, 0, 0);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 1, 0, 0);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 1, 0, 0);
    // taken branch wins over a coincident load-use
    add(1, i_ldr(4, 6),   0, 1, C_RUN, 2'b00, 2'b00, 1, 0, 0);
    add(1, i_add(5, 4, 4), 1, 1, C_BR,  2'b00, 2'b00, 1, 0, 0);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 1, 1, 0);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 1, 1, 0);
    // store stalls in MEM for 4 cycles; EX producer survives the freeze
    add(1, i_str(4, 6),   0, 1, C_RUN, 2'b00, 2'b00, 1, 1, 0);
    add(1, i_add(1, 6, 7), 0, 1, C_RUN, 2'b00, 2'b00, 1, 1, 0);
    add(1, i_add(2, 1, 3), 0, 0, C_FRZ, 2'b01, 2'b00, 1, 1, 0);
    add(1, i_add(2, 1, 3), 0, 0, C_FRZ, 2'b01, 2'b00, 1, 1, 1);
    add(1, i_add(2, 1, 3), 1, 0, C_FRZ, 2'b01, 2'b00, 1, 1, 2);
    add(1, i_add(2, 1, 3), 0, 0, C_FRZ, 2'b01, 2'b00, 1, 1, 3);
    add(1, i_add(2, 1, 3), 0, 1, C_RUN, 2'b01, 2'b00, 1, 1, 4);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 1, 1, 4);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 1, 1, 4);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 1, 1, 4);
    // R15 is never a hazard or forward source, even behind a load
    add(1, i_ldr(15, 6),  0, 1, C_RUN, 2'b00, 2'b00, 1, 1, 4);
    add(1, i_gen(1, 15, 3, 1, 1, 0, 0, 0, 0), 0, 1, C_RUN, 2'b00, 2'b00, 1, 1, 4);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 1, 1, 4);
    // reset in the middle of a memory wait
    add(1, i_str(4, 6),   0, 1, C_RUN, 2'b00, 2'b00, 1, 1, 4);
    add(1, i_nop(),       0, 1, C_RUN, 2'b00, 2'b00, 1, 1, 4);
    add(1, i_nop(),       0, 0, C_FRZ, 2'b00, 2'b00, 1, 1, 4);
    add(0, i_nop(),       0, 0, C_RST, 2'b00, 2'b00, 1, 1, 5);
    add(1, i_nop(),       0, 0, C_RUN, 2'b00, 2'b00, 0, 0, 0);

    drive(0, i_nop(), 0, 1);
    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].id, tbl[i].br, tbl[i].mrdy);
      @(negedge clk);
      check_vec(i, tbl[i].e);
      @(posedge clk); #1;
    end

    // 20 load-use stalls: the 16-bit counter counts them all, the 4-bit one sticks at 15
    for (int k = 0; k < 20; k++) begin
      drive(1, i_ldr(4, 4), 0, 1);
      @(negedge clk);
      chk($sformatf("sat_big_%0d", k), int'(stall_cnt), k);
      chk($sformatf("sat_small_%0d", k), int'(s_stall_cnt), (k > 15) ? 15 : k);
      @(posedge clk); #1;
      drive(1, i_add(5, 4, 4), 0, 1);
      @(negedge clk);
      chk($sformatf("sat_stall_pc_e_%0d", k), int'(s_pc_e), 0);
      @(posedge clk); #1;
    end
    drive(1, i_nop(), 0, 1);
    @(negedge clk);
    chk("sat_big_final", int'(stall_cnt), 20);
    chk("sat_small_final", int'(s_stall_cnt), 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central hazard scheduler for the 5-stage ARM pipeline.
- Keeps its own shadow of destination-register and write-enable state for the EX, MEM and WB stages.
- From that state it generates:
  - the PC enable and IF_ID enable/flush,
  - the bubble select for the control-signal multiplexer,
  - the operand forwarding selects for ID.
- Freezes the whole pipeline while data memory is busy, and keeps saturating performance counters.

Parameters:
- REG_AW, 4, register index width (R0–R15).
- CNT_W, 16, width of each performance counter.
- PC_REG, 15, register index that is never forwarded or hazard-checked.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; 0 on a rising clk edge resets the block.
- id_valid  in  1  ID holds a non-NOP instruction (instruction != 0).
- id_rn  in  REG_AW  first source register in ID.
- id_rm  in  REG_AW  second source register in ID.
- id_rn_used  in  1  id_rn is actually read.
- id_rm_used  in  1  id_rm is actually read.
- id_rd  in  REG_AW  destination register in ID.
- id_rf_e  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load.
- id_mem_e  in  1  ID instruction accesses data memory.
- ex_br_taken  in  1  branch/BL in EX resolved taken.
- mem_ready  in  1  data memory completes the access in MEM this cycle.
- pc_e  out  1  PC enable.
- if_id_e  out  1  IF_ID enable.
- if_id_flush  out  1  load 0 (NOP) into IF_ID.
- ctrl_mux_s  out  1  1 = inject bubble into ID_EX.
- pipe_freeze  out  1  hold ID_EX, EX_MEM and MEM_WB.
- fwd_a  out  2  forwarding select for Rn.
- fwd_b  out  2  forwarding select for Rm.
- stall_cnt  out  CNT_W  cycles of load-use stall.
- flush_cnt  out  CNT_W  taken-branch flushes.
- wait_cnt  out  CNT_W  cycles frozen on mem_ready.

Behaviour:
- Reset (reset=0 at clk edge):
  - Shadow stages cleared: rd=0, rf_e=0, load=0, mem_e=0.
  - FSM goes to RUN; all counters go to 0.
  - Combinational outputs while reset is held low: pc_e=0, if_id_e=0, if_id_flush=1, ctrl_mux_s=1, pipe_freeze=0, fwd_a=fwd_b=00.
  - Reset mid-MEM_WAIT abandons the wait without further side effects.
- Shadow pipeline (registered):
  - ID→EX→MEM→WB, advancing every cycle unless pipe_freeze=1.
  - ID→EX captures the ID fields, or zeros when ctrl_mux_s=1 or id_valid=0.
- Forward select, per operand:
  - Match requires the operand's *_used=1, register != PC_REG, and a matching stage with rf_e=1.
  - Priority EX (01) > MEM (10) > WB (11); no match gives 00 (register file).
  - A load in EX never yields 01; that case is a load-use hazard.
- Hazard terms:
  - load_use = EX.load & EX.rf_e & (Rn or Rm matches EX.rd under the forwarding qualifiers).
  - mem_busy = MEM.mem_e & !mem_ready.
- FSM states:
  - RUN → MEM_WAIT when mem_busy.
  - MEM_WAIT → RUN on the cycle mem_ready=1; that cycle is treated as RUN.
  - MEM_WAIT holds no other state.
- Output priority, highest first:
  1. mem_busy/MEM_WAIT: pipe_freeze=1, pc_e=0, if_id_e=0, if_id_flush=0, ctrl_mux_s=0, wait_cnt+1.
  2. ex_br_taken: pc_e=1 (PC loads the target), if_id_flush=1, ctrl_mux_s=1, flush_cnt+1. A coincident load_use is ignored and stall_cnt is not incremented.
  3. load_use: pc_e=0, if_id_e=0, ctrl_mux_s=1, stall_cnt+1. Exactly one stall cycle results, because the bubble clears EX.load. On the next cycle the consumer forwards from MEM (10).
  4. Otherwise: pc_e=1, if_id_e=1, all others 0.
- Latency: all enables and selects are combinational from the current shadow state and ID inputs. The shadow state updates at the clock edge.
- Counters: increment by 1 per qualifying cycle; saturate at all-ones with no wrap.
- ex_br_taken asserted during MEM_WAIT is ignored by this block. The EX stage holds it until the freeze ends.

Decomposition:
- Shared package pipeline_pkg holds:
  - FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11,
  - the FSM encoding (RUN=0, MEM_WAIT=1),
  - the PC_REG constant.
- Sub-module hazard_fwd_sel holds the per-operand priority compare. It is instantiated twice, for Rn and Rm.

Test Plan:
- Reset held low 3 cycles, then released → pc_e=0 and ctrl_mux_s=1 while low. After release: pc_e=1, all counters 0, fwd_a=fwd_b=00.
- ADD R1 then SUB R2,R1,R3 back-to-back → fwd_a=01 while SUB in ID. With one NOP between → 10. With two NOPs → 11.
- LDR R4 then ADD R5,R4,R4 → one cycle with pc_e=0, if_id_e=0, ctrl_mux_s=1, stall_cnt=1. Next cycle: fwd_a=fwd_b=10.
- ex_br_taken=1 in the same cycle as load_use → if_id_flush=1, ctrl_mux_s=1, pc_e=1, flush_cnt=1, stall_cnt=0.
- STR in MEM with mem_ready=0 for 4 cycles, then 1 → pipe_freeze=1 and pc_e=0 for 4 cycles, wait_cnt=4. Shadow state unchanged; the pipeline resumes on the 5th cycle.
- Source Rn=R15 matching EX.rd=15 → fwd_a=00, no stall. Also preload stall_cnt to 0xFFFF and force load_use → stall_cnt stays 0xFFFF.
